// File: rtl/instr_encoder_loader.sv
// Encodes instruction fields into 32-bit words and streams them into instruction memory while holding the core in reset.
// Latency: one cycle from the accepting edge to mem_we; each word costs two cycles (LOAD, WRITE).
// Backpressure: in_ready is high only in LOAD. Build option ENC_CHECK_EN rejects Op=11 and raises sticky err.
module instr_encoder_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rn,
  input  logic [3:0]  Rd,
  input  logic [11:0] Src2,
  input  logic [23:0] Imm24,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  input  logic        reload,
  output logic [8:0]  count,
  output logic        err
);

  typedef enum logic [1:0] {LOAD, WRITE, RUN} state_t;

  localparam logic [8:0] LAST_IDX = 9'(DEPTH - 1);

  state_t      state, state_nxt;
  logic [31:0] enc_word;
  logic [31:0] word_q;
  logic        last_q;
  logic        xfer;
  logic        illegal;

  assign xfer = in_valid & in_ready;

`ifdef ENC_CHECK_EN
  logic err_q;
  assign illegal = (Op == 2'b11);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (xfer && illegal) begin
      err_q <= 1'b1;
    end else if (state == RUN && reload) begin
      err_q <= 1'b0;
    end
  end
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  // Branches keep only the top two Funct bits; everything else uses the DP/memory layout.
  always_comb begin
    enc_word = {Cond, Op, Funct, Rn, Rd, Src2};
    if (Op == 2'b10) begin
      enc_word = {Cond, Op, Funct[5:4], Imm24};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (xfer) begin
          if (illegal) begin
            state_nxt = in_last ? RUN : LOAD;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        // Stopping at the last slot keeps mem_addr from ever wrapping.
        if (last_q || count == LAST_IDX) begin
          state_nxt = RUN;
        end else begin
          state_nxt = LOAD;
        end
      end
      RUN: begin
        if (reload) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD;
      count  <= 9'd0;
      word_q <= 32'd0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer && !illegal) begin
        word_q <= enc_word;
        last_q <= in_last;
      end
      if (state == WRITE) begin
        count <= count + 9'd1;
      end else if (state == RUN && reload) begin
        count <= 9'd0;
      end
    end
  end

  // A reset arriving during WRITE must squash the write in the same cycle.
  assign mem_we    = (state == WRITE) && !reset;
  assign mem_addr  = BASE_ADDR + {21'd0, count, 2'b00};
  assign mem_wdata = word_q;
  assign in_ready  = (state == LOAD);
  assign cpu_reset = (state != RUN);

endmodule
